// File: rtl/pipe_mux.sv
// ============================================================================
// Module      : pipe_mux
// Description : Registered N-way channel select feeding a 2-entry skid
//               buffer with valid/ready handshakes on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_mux #(
    parameter int WIDTH  = 5,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    flush,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_main_data;
    logic              r_main_err;
    logic [WIDTH-1:0]  r_skid_data;
    logic              r_skid_err;
    logic              r_out_valid;
    logic              r_in_ready;

    logic [WIDTH-1:0]  w_chan [NUM_IN];
    logic [WIDTH-1:0]  w_sel_data;
    logic              w_sel_err;
    logic              w_in_fire;
    logic              w_out_fire;

    generate
        for (genvar g = 0; g < NUM_IN; g++) begin : g_chan
            assign w_chan[g] = in_data[g*WIDTH +: WIDTH];
        end
    endgenerate

    // Any index with no matching channel yields zero data and the error flag.
    always_comb begin
        w_sel_data = '0;
        w_sel_err  = 1'b1;
        for (int k = 0; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                w_sel_data = w_chan[k];
                w_sel_err  = 1'b0;
            end
        end
    end

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_main_data <= '0;
            r_main_err  <= 1'b0;
            r_skid_data <= '0;
            r_skid_err  <= 1'b0;
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        r_main_data <= w_sel_data;
                        r_main_err  <= w_sel_err;
                        r_state     <= ST_ONE;
                        r_out_valid <= 1'b1;
                        r_in_ready  <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main_data <= w_sel_data;
                        r_main_err  <= w_sel_err;
                    end else if (w_in_fire) begin
                        r_skid_data <= w_sel_data;
                        r_skid_err  <= w_sel_err;
                        r_state     <= ST_TWO;
                        r_in_ready  <= 1'b0;
                    end else if (w_out_fire) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                ST_TWO: begin
                    if (w_out_fire) begin
                        r_main_data <= r_skid_data;
                        r_main_err  <= r_skid_err;
                        r_state     <= ST_ONE;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign out_data  = r_main_data;
    assign out_err   = r_main_err;
    assign out_valid = r_out_valid;
    assign in_ready  = r_in_ready;

endmodule

`default_nettype wire

// File: tb/tb_pipe_mux.sv
// ============================================================================
// Module      : tb_pipe_mux
// Description : Directed self-checking bench for pipe_mux (4- and 3-channel).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_mux;

    logic        clk;
    logic        rst;
    logic [19:0] in_data;
    logic [14:0] in_data3;
    logic [1:0]  in_sel;
    logic        in_valid;
    logic        flush;
    logic        out_ready;

    logic        in_ready;
    logic [4:0]  out_data;
    logic        out_err;
    logic        out_valid;

    logic        in_ready3;
    logic [4:0]  out_data3;
    logic        out_err3;
    logic        out_valid3;

    int n_checks;
    int n_fail;

    pipe_mux #(.WIDTH(5), .NUM_IN(4), .SEL_W(2)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_data  (out_data),
        .out_err   (out_err),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    pipe_mux #(.WIDTH(5), .NUM_IN(3), .SEL_W(2)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data3),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready3),
        .flush     (flush),
        .out_data  (out_data3),
        .out_err   (out_err3),
        .out_valid (out_valid3),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Channel values {3,7,12,31}; channel 0 in the low bits.
    logic [4:0] chan [4];

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        chan[0] = 5'd3; chan[1] = 5'd7; chan[2] = 5'd12; chan[3] = 5'd31;
        in_data   = {5'd31, 5'd12, 5'd7, 5'd3};
        in_data3  = {5'd12, 5'd7, 5'd3};
        in_sel    = 2'd0;
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        rst       = 1'b1;

        // Reset state
        step();
        check_val("rst_valid", 32'(out_valid), 0);
        check_val("rst_ready", 32'(in_ready), 1);
        check_val("rst_data", 32'(out_data), 0);
        check_val("rst_err", 32'(out_err), 0);
        rst = 1'b0;
        step();

        // Basic select
        in_sel = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
        step();
        check_val("basic_data", 32'(out_data), 12);
        check_val("basic_err", 32'(out_err), 0);
        check_val("basic_valid", 32'(out_valid), 1);
        check_val("basic_data3", 32'(out_data3), 12);

        // Out-of-range select on the 3-channel instance
        in_sel = 2'd3;
        step();
        check_val("oor_data3", 32'(out_data3), 0);
        check_val("oor_err3", 32'(out_err3), 1);
        check_val("inr_data4", 32'(out_data), 31);
        check_val("inr_err4", 32'(out_err), 0);
        in_valid = 1'b0;
        step();
        check_val("drain_valid", 32'(out_valid), 0);

        // Backpressure: A=ch0, B=ch1, C=ch3
        out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd0;
        step();
        check_val("bp_a_data", 32'(out_data), 3);
        check_val("bp_a_ready", 32'(in_ready), 1);
        in_sel = 2'd1;
        step();
        check_val("bp_b_ready", 32'(in_ready), 0);
        check_val("bp_b_data", 32'(out_data), 3);
        in_sel = 2'd3;
        step();
        check_val("bp_c_ready", 32'(in_ready), 0);
        check_val("bp_hold_data", 32'(out_data), 3);
        check_val("bp_hold_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        step();
        check_val("bp_out_b", 32'(out_data), 7);
        check_val("bp_ready_back", 32'(in_ready), 1);
        step();
        check_val("bp_out_c", 32'(out_data), 31);
        check_val("bp_out_c_valid", 32'(out_valid), 1);
        in_valid = 1'b0;
        step();
        check_val("bp_empty", 32'(out_valid), 0);

        // Streaming 8 items
        out_ready = 1'b1; in_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            in_sel = 2'(k % 4);
            step();
            check_val("stream_data", 32'(out_data), 32'(chan[k % 4]));
            check_val("stream_valid", 32'(out_valid), 1);
            check_val("stream_ready", 32'(in_ready), 1);
        end
        in_valid = 1'b0;
        step();
        check_val("stream_empty", 32'(out_valid), 0);

        // Flush from TWO with an input offered
        out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd0;
        step();
        in_sel = 2'd1;
        step();
        check_val("fl_two_ready", 32'(in_ready), 0);
        flush = 1'b1; in_sel = 2'd2;
        step();
        check_val("fl_valid", 32'(out_valid), 0);
        check_val("fl_ready", 32'(in_ready), 1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step();
        check_val("fl_gone1", 32'(out_valid), 0);
        step();
        check_val("fl_gone2", 32'(out_valid), 0);

        // Reset mid-stream in TWO
        out_ready = 1'b0; in_valid = 1'b1; in_sel = 2'd1;
        step();
        in_sel = 2'd2;
        step();
        check_val("rm_two_ready", 32'(in_ready), 0);
        rst = 1'b1; in_valid = 1'b0;
        step();
        check_val("rm_valid", 32'(out_valid), 0);
        check_val("rm_data", 32'(out_data), 0);
        check_val("rm_ready", 32'(in_ready), 1);
        rst = 1'b0; in_valid = 1'b1; in_sel = 2'd3; out_ready = 1'b1;
        step();
        check_val("rm_next_data", 32'(out_data), 31);
        check_val("rm_next_valid", 32'(out_valid), 1);
        in_valid = 1'b0;
        step();
        check_val("rm_final_empty", 32'(out_valid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
